// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction fetch memory.
package imem_pkg;

    localparam int DATA_W      = 32;
    localparam int LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } imem_state_e;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] dat;
    } imem_rsp_t;

endpackage

// File: rtl/imem_lat_pipe.sv
// Delay line that carries a captured fetch word toward the response register.
// Latency: DEPTH cycles (DEPTH=0 is a combinational pass-through).
// Backpressure: none; the fetch FSM admits at most one word in flight.
module imem_lat_pipe
    import imem_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      in_vld,
    input  imem_rsp_t in_rsp,
    output logic      out_vld,
    output imem_rsp_t out_rsp
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic clk_rst_unused;
            assign clk_rst_unused = clk ^ reset;
            assign out_vld        = in_vld;
            assign out_rsp        = in_rsp;
        end else begin : g_shift
            logic [DEPTH-1:0] vld_q;
            imem_rsp_t        rsp_q [DEPTH];

            // Reset drops the valid bits so a fetch in flight never surfaces.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q <= '0;
                    for (int i = 0; i < DEPTH; i++) rsp_q[i] <= '0;
                end else begin
                    vld_q[0] <= in_vld;
                    rsp_q[0] <= in_rsp;
                    for (int i = 1; i < DEPTH; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        rsp_q[i] <= rsp_q[i-1];
                    end
                end
            end

            assign out_vld = vld_q[DEPTH-1];
            assign out_rsp = rsp_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction memory with a clear sweep after reset, a load port and one-deep fetch.
// Latency: LATENCY cycles from request acceptance to rsp_valid; clear takes MEM_DEPTH cycles.
// Backpressure: rsp held until rsp_ready; IMEM_ERR_CHECK_EN enables address error reporting.
module inst_fetch_mem
    import imem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [31:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              clr_busy
);

    localparam int          IDX_W    = $clog2(MEM_DEPTH);
    localparam imem_state_e ISSUE_ST = (LATENCY == 1) ? RESP : WAIT;

    imem_state_e       state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    imem_rsp_t         rsp_q;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic [IDX_W-1:0]  fetch_idx, ld_idx;
    logic              fetch_ok, ld_ok, accept, ld_wr, pipe_vld;
    imem_rsp_t         fetch_rsp, pipe_rsp;

    assign fetch_idx = req_addr[IDX_W+1:2];
    assign ld_idx    = ld_addr[IDX_W+1:2];

`ifdef IMEM_ERR_CHECK_EN
    assign fetch_ok = (req_addr[1:0] == 2'b00) && ((req_addr >> (IDX_W + 2)) == 32'd0);
    assign ld_ok    = (ld_addr[1:0] == 2'b00) && ((ld_addr >> (IDX_W + 2)) == 32'd0);
`else
    logic addr_unused;
    assign addr_unused = ^{req_addr[31:IDX_W+2], req_addr[1:0], ld_addr[31:IDX_W+2], ld_addr[1:0]};
    assign fetch_ok    = 1'b1;
    assign ld_ok       = 1'b1;
`endif

    // The read is taken before this edge's load lands, so a same-edge load yields the old word.
    assign fetch_rsp.err = !fetch_ok;
    assign fetch_rsp.dat = fetch_ok ? mem_q[fetch_idx] : '0;

    assign accept = req_valid && req_ready;
    assign ld_wr  = ld_en && (state_q != CLEAR) && ld_ok;

    imem_lat_pipe #(
        .DEPTH (LATENCY - 1)
    ) u_lat_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (accept),
        .in_rsp  (fetch_rsp),
        .out_vld (pipe_vld),
        .out_rsp (pipe_rsp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_q <= '0;
        end else if (pipe_vld) begin
            rsp_q <= pipe_rsp;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (ld_wr) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == IDX_W'(MEM_DEPTH - 1)) state_d = IDLE;
            end
            IDLE:    if (accept) state_d = ISSUE_ST;
            WAIT:    if (pipe_vld) state_d = RESP;
            RESP:    if (rsp_ready) state_d = accept ? ISSUE_ST : IDLE;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        clr_busy  = 1'b0;
        case (state_q)
            CLEAR: clr_busy = 1'b1;
            IDLE:  req_ready = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
            end
            default: ;
        endcase
    end

    assign rsp_data = rsp_q.dat;
    assign rsp_err  = rsp_q.err;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Randomised and directed bench for inst_fetch_mem against a word-array reference model.
module tb_inst_fetch_mem;

    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic        clk, reset;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ld_en, clr_busy;
    logic [31:0] req_addr, rsp_data, ld_addr, ld_data;

    inst_fetch_mem #(
        .MEM_DEPTH (DEPTH),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .clr_busy  (clr_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          vec_cnt  = 0;
    int          miss_cnt = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    bit          shown, accepted, acc_on_hs;
    logic [31:0] last_dat;
    logic        last_err;
    logic [31:0] w0, w1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
`ifdef IMEM_ERR_CHECK_EN
        return (a % 4 == 0) && (a / 4 < DEPTH);
`else
        return (a == a);
`endif
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    task automatic ref_clear();
        foreach (ref_mem[i]) ref_mem[i] = '0;
        exp_q.delete();
        shown = 0;
    endtask

    // One clock: drive inputs, score the visible outputs, update the model, advance.
    task automatic step(input bit rv, input logic [31:0] ra, input bit rr,
                        input bit le, input logic [31:0] la, input logic [31:0] ld);
        exp_t e;
        bit   hs;
        req_valid = rv; req_addr = ra; rsp_ready = rr;
        ld_en = le; ld_addr = la; ld_data = ld;
        #1;
        accepted = 0; acc_on_hs = 0; hs = 0;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                if (!shown) begin
                    chk("latency", 32'(cyc - acc_cyc), 32'(LAT));
                    shown = 1;
                end
                chk("rsp_data", rsp_data, exp_q[0].dat);
                chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                chk("rdy_resp", 32'(req_ready), 32'(rr));
                if (rr) begin
                    hs = 1;
                    last_dat = rsp_data;
                    last_err = rsp_err;
                    void'(exp_q.pop_front());
                    shown = 0;
                end
            end
        end else begin
            chk("rdy_state", 32'(req_ready), 32'(exp_q.size() == 0));
        end
        if (rv && req_ready) begin
            chk("one_in_flight", 32'(exp_q.size()), 32'd0);
            e.err = !addr_ok(ra);
            e.dat = e.err ? 32'd0 : ref_mem[widx(ra)];
            exp_q.push_back(e);
            acc_cyc   = cyc;
            accepted  = 1;
            acc_on_hs = hs;
        end
        if (le && addr_ok(la)) ref_mem[widx(la)] = ld;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        step(0, 32'd0, 1, 1, a, d);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step(0, 32'd0, 1, 0, 32'd0, 32'd0);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] a);
        int n = 0;
        accepted = 0;
        while (!accepted && n < 50) begin
            step(1, a, 1, 0, 32'd0, 32'd0);
            n++;
        end
        chk("accept_timeout", 32'(accepted), 32'd1);
        drain();
    endtask

    // Clear sweep with hostile inputs: requests and loads must both be ignored.
    task automatic sweep();
        int n = 0;
        req_valid = 1; req_addr = 32'h40; rsp_ready = 1;
        ld_en = 1; ld_addr = 32'h40; ld_data = 32'hBAD0_BAD0;
        while (clr_busy && n < 2000) begin
            n++;
            chk("clr_rdy", 32'(req_ready), 32'd0);
            chk("clr_vld", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        req_valid = 0; ld_en = 0; req_addr = 0; ld_addr = 0; ld_data = 0;
        chk("clr_cycles", 32'(n), 32'd1024);
        chk("rdy_after_clr", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, la;
        int n;
        reset = 1'b1; req_valid = 0; req_addr = 0; rsp_ready = 0;
        ld_en = 0; ld_addr = 0; ld_data = 0;
        #2 reset = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        ref_clear();
        sweep();

        fetch(32'h40);
        chk("fetch_40", last_dat, 32'h0000_0000);

        load(32'h8, 32'h0050_0093);
        fetch(32'h8);
        chk("fetch_8", last_dat, 32'h0050_0093);

        // Backpressure then zero-bubble follow-on requests.
        w0 = $urandom; w1 = $urandom;
        load(32'h0, w0);
        load(32'h4, w1);
        step(1, 32'h8, 0, 0, 32'd0, 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step(0, 32'd0, 0, 0, 32'd0, 32'd0);
            n++;
        end
        repeat (5) begin
            step(1, 32'h0, 0, 0, 32'd0, 32'd0);
            chk("bp_hold", rsp_data, 32'h0050_0093);
        end
        step(1, 32'h0, 1, 0, 32'd0, 32'd0);
        chk("zb_first", 32'(acc_on_hs), 32'd1);
        accepted = 0; n = 0;
        while (!accepted && n < 20) begin
            step(1, 32'h4, 1, 0, 32'd0, 32'd0);
            n++;
        end
        chk("zb_second", 32'(acc_on_hs), 32'd1);
        chk("bb_word0", last_dat, w0);
        drain();
        chk("bb_word1", last_dat, w1);

`ifdef IMEM_ERR_CHECK_EN
        fetch(32'h6);
        chk("err_misalign", 32'(last_err), 32'd1);
        chk("err_misalign_dat", last_dat, 32'd0);
        fetch(32'h1000);
        chk("err_range", 32'(last_err), 32'd1);
`else
        fetch(32'h1000);
        chk("wrap_1000", last_dat, w0);
        chk("wrap_err", 32'(last_err), 32'd0);
`endif

        load(32'h10, 32'h11);
        step(1, 32'h10, 1, 1, 32'h10, 32'h22);
        chk("same_edge_acc", 32'(accepted), 32'd1);
        drain();
        chk("same_edge_old", last_dat, 32'h11);
        fetch(32'h10);
        chk("same_edge_new", last_dat, 32'h22);

        for (int i = 0; i < 400; i++) begin
            ra = 32'($urandom_range(0, DEPTH * 2 - 1)) * 4;
            if ($urandom_range(0, 7) == 0) ra = ra | 32'($urandom_range(1, 3));
            la = 32'($urandom_range(0, DEPTH * 2 - 1)) * 4;
            step(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), la, $urandom);
        end
        drain();

        // Reset while the fetch sits in WAIT.
        load(32'h20, 32'hDEAD_BEEF);
        step(1, 32'h20, 1, 0, 32'd0, 32'd0);
        step(0, 32'd0, 1, 0, 32'd0, 32'd0);
        reset = 1'b0;
        #1;
        chk("midrst_vld", 32'(rsp_valid), 32'd0);
        chk("midrst_rdy", 32'(req_ready), 32'd0);
        chk("midrst_busy", 32'(clr_busy), 32'd1);
        ref_clear();
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("midrst_novld", 32'(rsp_valid), 32'd0);
        end
        reset = 1'b1;
        sweep();
        fetch(32'h20);
        chk("post_rst_word", last_dat, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/inst_fetch_mem.md
INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, number of 32-bit instruction words (power of two, >=4).
REQ-002 SHALL have parameter LATENCY, default 1, accept-to-rsp_valid cycles (legal 1..4).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  fetch request present.
REQ-006 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_addr  in  32  byte address of instruction.
REQ-008 SHALL have port rsp_valid  out  1  response word available.
REQ-009 SHALL have port rsp_ready  in  1  consumer takes response.
REQ-010 SHALL have port rsp_data  out  32  fetched instruction.
REQ-011 SHALL have port rsp_err  out  1  fetch error flag, qualified by rsp_valid.
REQ-012 SHALL have port ld_en  in  1  program-load write strobe.
REQ-013 SHALL have port ld_addr  in  32  load byte address; word index = ld_addr>>2.
REQ-014 SHALL have port ld_data  in  32  load word.
REQ-015 SHALL have port clr_busy  out  1  high while memory clear sweep runs.

Function
REQ-016 SHALL implement FSM states CLEAR, IDLE, WAIT, RESP; word index = req_addr>>2.
REQ-017 SHALL in CLEAR write zero to one word per cycle, index 0..MEM_DEPTH-1, then enter IDLE; clr_busy=1, req_ready=0, ld_en ignored during CLEAR.
REQ-018 SHALL drive req_ready=1 in IDLE, and in RESP only in a cycle where rsp_ready=1; 0 in CLEAR and WAIT.
REQ-019 SHALL capture memory word at acceptance edge; rsp_valid rises exactly LATENCY cycles after acceptance edge (WAIT occupied LATENCY-1 cycles; LATENCY=1 goes directly to RESP).
REQ-020 SHALL hold rsp_data, rsp_err, rsp_valid stable in RESP until rsp_valid&&rsp_ready.
REQ-021 SHALL on RESP handshake with new request accepted same cycle go to WAIT/RESP for new request (zero bubble); without new request go to IDLE with rsp_valid=0.
REQ-022 SHALL write ld_data at ld_en in IDLE, WAIT or RESP; a load to the index being captured the same edge returns the old word.
REQ-023 SHALL never have more than one request in flight.

Reset
REQ-024 SHALL on reset low immediately force rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=0, clr_busy=1, state CLEAR, clear counter 0.
REQ-025 SHALL on reset mid-fetch discard the in-flight request; no response is ever produced for it.
REQ-026 SHALL restart the full clear sweep on reset release; memory contents are not preserved across reset.

Configuration
REQ-027 SHALL with IMEM_ERR_CHECK_EN defined set rsp_err=1 and rsp_data=0 when req_addr[1:0]!=0 or word index >= MEM_DEPTH, and ignore ld_en writes to such addresses.
REQ-028 SHALL without IMEM_ERR_CHECK_EN tie rsp_err=0, ignore addr[1:0], and wrap index modulo MEM_DEPTH for both fetch and load.

Structure
REQ-029 SHALL place FSM state enum, DATA_W=32 and LATENCY_MAX=4 constants in shared package imem_pkg.
REQ-030 SHALL implement latency delay as sub-module imem_lat_pipe (valid/data/err shift stage, depth LATENCY-1).

Verification
REQ-031 SHALL verify reset release: clr_busy=1 for exactly 1024 cycles, then req_ready=1; fetch 0x40 -> rsp_data=0x00000000.
REQ-032 SHALL verify load then fetch: ld 0x8 <- 0x00500093; fetch 0x8 with LATENCY=3 -> rsp_valid 3 cycles after accept, data 0x00500093.
REQ-033 SHALL verify backpressure: rsp_ready=0 for 5 cycles -> rsp_data held, req_ready=0; then back-to-back fetch 0x0,0x4 accepted without bubble.
REQ-034 SHALL verify IMEM_ERR_CHECK_EN: fetch 0x6 -> rsp_err=1, data 0; fetch 0x1000 (depth 1024) -> rsp_err=1; without macro 0x1000 returns word 0.
REQ-035 SHALL verify reset asserted during WAIT -> rsp_valid never rises for that request; after sweep, prior-loaded word reads 0.
REQ-036 SHALL verify same-edge load and fetch to 0x10 (old 0x11, new 0x22) -> response 0x11, next fetch 0x22.
